// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S path: default sample width and the RPi receiver FSM encoding.
package i2s_pkg;

  localparam int unsigned SAMPLE_W_DFLT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PUSH  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO is only accepted if a pop happens in the same cycle.
module sync_fifo #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic [LVL_W-1:0] level_next_c
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == LVL_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    level_next_c = cnt;
    if (do_push && !do_pop) begin
      level_next_c = cnt + LVL_W'(1);
    end else if (!do_push && do_pop) begin
      level_next_c = cnt - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      cnt <= level_next_c;
    end
  end

  assign rdata = mem[rd_ptr];
  assign level = cnt;

endmodule

// File: rtl/rpi_sample_rx.sv
// Receives MSB-first sample words from the RPi serial link into the clk domain, buffers
// them in a FIFO for the I2S shifter and requests more data when the FIFO runs low.
module rpi_sample_rx
  import i2s_pkg::*;
#(
  parameter  int unsigned SAMPLE_W  = i2s_pkg::SAMPLE_W_DFLT,
  parameter  int unsigned DEPTH     = 8,
  parameter  int unsigned LOW_WATER = 2,
  localparam int unsigned LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                ar,
  input  logic                rpi_clk,
  input  logic                rpi_serial,
  input  logic                rpi_enable,
  output logic                rpi_interrupt,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic [LVL_W-1:0]    level,
  output logic                overflow
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_W);

  logic rclk_s1, rclk_s2, rclk_s3;
  logic ser_s1, ser_s2;
  logic en_s1, en_s2;
  logic rise;

  rx_state_t            state;
  logic [SAMPLE_W-1:0]  shreg;
  logic [CNT_W-1:0]     bit_cnt;

  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LVL_W-1:0]     level_next;

  // Two-flop synchronisers; the extra rpi_clk stage feeds the rising-edge detector
  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      rclk_s1 <= 1'b0;
      rclk_s2 <= 1'b0;
      rclk_s3 <= 1'b0;
      ser_s1  <= 1'b0;
      ser_s2  <= 1'b0;
      en_s1   <= 1'b0;
      en_s2   <= 1'b0;
    end else begin
      rclk_s1 <= rpi_clk;
      rclk_s2 <= rclk_s1;
      rclk_s3 <= rclk_s2;
      ser_s1  <= rpi_serial;
      ser_s2  <= ser_s1;
      en_s1   <= rpi_enable;
      en_s2   <= en_s1;
    end
  end

  assign rise = rclk_s2 & ~rclk_s3;

  // Deserialiser: a dropped enable mid-word silently discards the partial word
  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en_s2) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (!en_s2) begin
            state <= ST_IDLE;
          end else if (rise) begin
            shreg   <= {shreg[SAMPLE_W-2:0], ser_s2};
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(SAMPLE_W - 1)) begin
              state <= ST_PUSH;
            end
          end
        end
        ST_PUSH: begin
          bit_cnt <= '0;
          state   <= en_s2 ? ST_SHIFT : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign push = (state == ST_PUSH);
  assign pop  = sample_valid & sample_ready;

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (ar),
    .push         (push),
    .wdata        (shreg),
    .pop          (pop),
    .rdata        (sample_data),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .level        (level),
    .level_next_c (level_next)
  );

  assign sample_valid = ~fifo_empty;

  // Overflow is sticky; interrupt tracks the level the FIFO is about to take
  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      rpi_interrupt <= 1'b1;
      overflow      <= 1'b0;
    end else begin
      rpi_interrupt <= (level_next <= LVL_W'(LOW_WATER));
      if (push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rpi_sample_rx.sv
// Randomised and directed bench for rpi_sample_rx against a queue-based model of the FIFO contents.
module tb_rpi_sample_rx;

  localparam int SW    = 16;
  localparam int DEPTH = 8;
  localparam int LW    = 2;
  localparam int LVL_W = 4;

  logic          clk          = 1'b0;
  logic          ar           = 1'b1;
  logic          rpi_clk      = 1'b0;
  logic          rpi_serial   = 1'b0;
  logic          rpi_enable   = 1'b0;
  logic          sample_ready = 1'b0;
  logic          rpi_interrupt;
  logic [SW-1:0] sample_data;
  logic          sample_valid;
  logic [LVL_W-1:0] level;
  logic          overflow;

  int total = 0;
  int bad   = 0;
  logic [SW-1:0] exp_q [$];
  logic          exp_ovf = 1'b0;

  always #5 clk = ~clk;

  rpi_sample_rx #(
    .SAMPLE_W  (SW),
    .DEPTH     (DEPTH),
    .LOW_WATER (LW)
  ) dut (
    .clk           (clk),
    .ar            (ar),
    .rpi_clk       (rpi_clk),
    .rpi_serial    (rpi_serial),
    .rpi_enable    (rpi_enable),
    .rpi_interrupt (rpi_interrupt),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .level         (level),
    .overflow      (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every handshake must deliver the oldest outstanding word
  always @(posedge clk) begin
    if (ar && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) check("spurious_valid", 32'(sample_valid), 32'd0);
      else                   check("pop_data", 32'(sample_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    int sz = exp_q.size();
    check({tag, "_lvl"}, 32'(level), 32'(sz));
    check({tag, "_vld"}, 32'(sample_valid), 32'(sz != 0));
    check({tag, "_irq"}, 32'(rpi_interrupt), 32'(sz <= LW));
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic do_reset();
    ar           = 1'b0;
    rpi_enable   = 1'b0;
    rpi_clk      = 1'b0;
    sample_ready = 1'b0;
    tick(2);
    exp_q.delete();
    exp_ovf = 1'b0;
    ar = 1'b1;
    tick(1);
  endtask

  task automatic send_bit(input logic b, input int per);
    rpi_serial = b;
    tick(per / 4);
    rpi_clk = 1'b1;
    tick(per / 2);
    rpi_clk = 1'b0;
    tick(per - per / 4 - per / 2);
  endtask

  // Sends one word; the final bit is timed so the push latency can be observed
  task automatic send_word(input logic [SW-1:0] w, input int per, input bit simul, input bit keep_en);
    if (!rpi_enable) begin
      rpi_enable = 1'b1;
      tick(2);
    end
    for (int i = SW - 1; i >= 1; i--) send_bit(w[i], per);
    rpi_serial = w[0];
    tick(per / 4);
    rpi_clk = 1'b1;
    tick(3);
    check("prepush_lvl", 32'(level), 32'(exp_q.size()));
    check("prepush_vld", 32'(sample_valid), 32'(exp_q.size() != 0));
    if (simul) sample_ready = 1'b1;
    tick(1);
    if (simul) sample_ready = 1'b0;
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
    else                      exp_ovf = 1'b1;
    check_state("push");
    if (exp_q.size() == 1) check("push_data", 32'(sample_data), 32'(w));
    rpi_clk = 1'b0;
    if (!keep_en) begin
      rpi_enable = 1'b0;
      tick(3);
    end
  endtask

  task automatic drain(input bit rnd);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      sample_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick(1);
      check_state("drain");
      n++;
    end
    sample_ready = 1'b0;
    tick(1);
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check_state("drained");
  endtask

  initial begin
    #2;
    do_reset();
    check_state("por");

    // Reset in the middle of a word
    rpi_enable = 1'b1;
    tick(2);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 6);
    do_reset();
    check_state("rst");
    check("rst_data", 32'(sample_data), 32'd0);

    // Single word, then pop it
    send_word(16'hA5C3, 8, 1'b0, 1'b0);
    check("single_data", 32'(sample_data), 32'hA5C3);
    sample_ready = 1'b1;
    tick(1);
    sample_ready = 1'b0;
    check_state("single_pop");

    // Abort after 9 bits, then a full word
    rpi_enable = 1'b1;
    tick(2);
    for (int i = 0; i < 9; i++) send_bit(1'($urandom_range(0, 1)), 6);
    rpi_enable = 1'b0;
    tick(4);
    check_state("abort");
    send_word(16'h1234, 6, 1'b0, 1'b0);
    check("abort_data", 32'(sample_data), 32'h1234);
    drain(1'b0);

    // Fill past full, then drain one per cycle watching the interrupt
    for (int k = 0; k < 9; k++) send_word(SW'(k), $urandom_range(4, 8), 1'b0, 1'b0);
    check("fill_ovf", 32'(overflow), 32'd1);
    drain(1'b0);

    // Push and pop on the same cycle while full
    do_reset();
    for (int k = 0; k < DEPTH; k++) send_word(SW'($urandom), $urandom_range(4, 8), 1'b0, 1'b0);
    send_word(16'hBEEF, 5, 1'b1, 1'b0);
    check("simul_lvl", 32'(level), 32'd8);
    check("simul_last", 32'(exp_q[DEPTH-1]), 32'hBEEF);
    drain(1'b1);

    // Back-to-back words at the minimum bit period with the shifter always ready
    sample_ready = 1'b1;
    for (int k = 0; k < 4; k++) send_word(SW'($urandom), 4, 1'b0, k < 3);
    tick(3);
    sample_ready = 1'b0;
    tick(1);
    check_state("b2b");

    // Random bursts and drains
    for (int r = 0; r < 5; r++) begin
      int n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) send_word(SW'($urandom), $urandom_range(4, 10), 1'b0, 1'b0);
      drain(1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
